// File: rtl/mad_best_match_if.sv
// Candidate-result and best-match status bundle between the SAD pipeline, the
// best-match tracker and the motion-estimation controller.
interface mad_best_match_if #(
    parameter int unsigned CNT_W = 10
);
    localparam int unsigned SAD_W  = 13;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned RES_W  = SAD_W + ADDR_W;

    logic                start;
    logic                res_valid;
    logic [RES_W-1:0]    res_in;
    logic                busy;
    logic                done;
    logic [SAD_W-1:0]    best_sad;
    logic [ADDR_W-1:0]   best_addr;
    logic [CNT_W-1:0]    cand_cnt;

    // Tracker side: consumes results, reports the winner.
    modport slave (
        input  start,
        input  res_valid,
        input  res_in,
        output busy,
        output done,
        output best_sad,
        output best_addr,
        output cand_cnt
    );

    // Controller / pipeline side.
    modport master (
        output start,
        output res_valid,
        output res_in,
        input  busy,
        input  done,
        input  best_sad,
        input  best_addr,
        input  cand_cnt
    );
endinterface

// File: rtl/mad_best_match.sv
// Minimum-SAD tracker over one search window; reports winning SAD/address with a done pulse.
// Optional early termination on a good-enough SAD when MAD_BEST_EARLY_EN is defined.
module mad_best_match #(
    parameter int unsigned NUM_CAND     = 289,
    parameter int unsigned CNT_W        = 10,
    parameter int unsigned EARLY_THRESH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mad_best_match_if.slave   bus
);
    localparam int unsigned SAD_W  = 13;
    localparam int unsigned ADDR_W = 8;

    typedef struct packed {
        logic [SAD_W-1:0]  sad;
        logic [ADDR_W-1:0] addr;
    } res_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [SAD_W-1:0] SAD_INIT = SAD_W'(13'h1FFF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CAND);

    // Elaboration-time parameter sanity checks.
    if (NUM_CAND < 1 || NUM_CAND > 1023) begin : g_bad_num_cand
        $error("mad_best_match: NUM_CAND out of range 1..1023");
    end
    if ((64'd1 << CNT_W) <= 64'(NUM_CAND)) begin : g_bad_cnt_w
        $error("mad_best_match: CNT_W too narrow for NUM_CAND");
    end
    if (EARLY_THRESH > 32'h1FFF) begin : g_bad_thresh
        $error("mad_best_match: EARLY_THRESH exceeds SAD range");
    end

    state_t              state_q,     state_d;
    logic [SAD_W-1:0]    best_sad_q,  best_sad_d;
    logic [ADDR_W-1:0]   best_addr_q, best_addr_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    res_t                res;
    logic [CNT_W-1:0]    cnt_inc;
    logic                better;
    logic                stop_now;

    assign res     = res_t'(bus.res_in);
    assign cnt_inc = CNT_W'(cnt_q + 1'b1);
    // Strict compare so ties keep the earliest candidate.
    assign better  = (res.sad < best_sad_q);

`ifdef MAD_BEST_EARLY_EN
    assign stop_now = (cnt_inc == CNT_LAST) || (res.sad <= SAD_W'(EARLY_THRESH));
`else
    assign stop_now = (cnt_inc == CNT_LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            best_sad_q  <= SAD_INIT;
            best_addr_q <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            best_sad_q  <= best_sad_d;
            best_addr_q <= best_addr_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and datapath; start always wins over a same-cycle result.
    always_comb begin
        state_d     = state_q;
        best_sad_d  = best_sad_q;
        best_addr_d = best_addr_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = SEARCH;
                    best_sad_d  = SAD_INIT;
                    best_addr_d = '0;
                    cnt_d       = '0;
                end
            end
            SEARCH: begin
                if (bus.start) begin
                    best_sad_d  = SAD_INIT;
                    best_addr_d = '0;
                    cnt_d       = '0;
                end else if (bus.res_valid) begin
                    cnt_d = cnt_inc;
                    if (better) begin
                        best_sad_d  = res.sad;
                        best_addr_d = res.addr;
                    end
                    if (stop_now) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d     = SEARCH;
                    best_sad_d  = SAD_INIT;
                    best_addr_d = '0;
                    cnt_d       = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered copies of the upcoming state.
        busy_d = (state_d == SEARCH);
        done_d = (state_d == DONE);
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.best_sad  = best_sad_q;
    assign bus.best_addr = best_addr_q;
    assign bus.cand_cnt  = cnt_q;

endmodule

// File: tb/tb_mad_best_match.sv
// Scoreboard bench for mad_best_match with a 4-candidate window.
module tb_mad_best_match;
    localparam int unsigned NC = 4;
    localparam int unsigned CW = 10;
    localparam int unsigned ET = 16;
`ifdef MAD_BEST_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic [12:0]   sad;
        logic [7:0]    addr;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mad_best_match_if #(.CNT_W(CW)) bif ();

    mad_best_match #(
        .NUM_CAND    (NC),
        .CNT_W       (CW),
        .EARLY_THRESH(ET)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    exp_t        sb[$];
    exp_t        e;
    int          n_vec    = 0;
    int          n_err    = 0;
    int          done_cnt = 0;
    int          d0;
    bit          m_act    = 1'b0;
    logic [12:0] m_sad;
    logic [7:0]  m_addr;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start();
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        m_act  = 1'b1;
        m_sad  = 13'h1FFF;
        m_addr = 8'h00;
        m_cnt  = 0;
    endtask

    // Drive one accepted candidate and advance the reference model.
    task automatic send(input logic [12:0] sad, input logic [7:0] addr);
        bif.res_valid = 1'b1;
        bif.res_in    = {sad, addr};
        if (m_act) begin
            m_cnt++;
            if (sad < m_sad) begin
                m_sad  = sad;
                m_addr = addr;
            end
            if (m_cnt == NC || (EARLY && sad <= 13'(ET))) begin
                sb.push_back('{sad: m_sad, addr: m_addr, cnt: CW'(m_cnt)});
                m_act = 1'b0;
            end
        end
        step();
        bif.res_valid = 1'b0;
    endtask

    // Completion monitor: every done pulse must match a queued window result.
    always @(negedge clk) begin
        if (rst_n && bif.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_sad",  32'(bif.best_sad),  32'(e.sad));
                check("sb_addr", 32'(bif.best_addr), 32'(e.addr));
                check("sb_cnt",  32'(bif.cand_cnt),  32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bif.start     = 1'b0;
        bif.res_valid = 1'b0;
        bif.res_in    = '0;
        idle(3);
        rst_n = 1'b1;
        step();
        check("rst_busy", 32'(bif.busy),     32'd0);
        check("rst_done", 32'(bif.done),     32'd0);
        check("rst_sad",  32'(bif.best_sad), 32'h1FFF);
        check("rst_addr", 32'(bif.best_addr), 32'd0);
        check("rst_cnt",  32'(bif.cand_cnt), 32'd0);

        // Results presented in IDLE are ignored.
        bif.res_valid = 1'b1;
        bif.res_in    = {13'd5, 8'h33};
        idle(3);
        bif.res_valid = 1'b0;
        check("idle_sad",  32'(bif.best_sad), 32'h1FFF);
        check("idle_cnt",  32'(bif.cand_cnt), 32'd0);
        check("idle_done", 32'(done_cnt),     32'd0);

        // Full window with a tie.
        pulse_start();
        check("win_busy", 32'(bif.busy),     32'd1);
        check("win_cnt0", 32'(bif.cand_cnt), 32'd0);
        send(13'd40, 8'h10);
        send(13'd25, 8'h11);
        send(13'd25, 8'h12);
        check("win_nodone", 32'(bif.done), 32'd0);
        send(13'd30, 8'h13);
        check("win_done",  32'(bif.done),      32'd1);
        check("win_busy0", 32'(bif.busy),      32'd0);
        check("win_sad",   32'(bif.best_sad),  32'd25);
        check("win_addr",  32'(bif.best_addr), 32'h11);
        check("win_cnt",   32'(bif.cand_cnt),  32'd4);
        step();
        check("win_pulse", 32'(bif.done),     32'd0);
        check("win_hold",  32'(bif.best_sad), 32'd25);
        check("win_ndone", 32'(done_cnt),     32'd1);

        // Gaps between samples, last sample wins.
        d0 = done_cnt;
        pulse_start();
        send(13'd100, 8'h01);
        idle(3);
        check("gap_cnt1", 32'(bif.cand_cnt), 32'd1);
        check("gap_sad1", 32'(bif.best_sad), 32'd100);
        send(13'd90, 8'h02);
        idle(1);
        send(13'd200, 8'h03);
        check("gap_cnt3",   32'(bif.cand_cnt), 32'd3);
        check("gap_sad3",   32'(bif.best_sad), 32'd90);
        check("gap_nodone", 32'(done_cnt),     32'(d0));
        idle(2);
        send(13'd7, 8'hF7);
        check("gap_done", 32'(bif.done),      32'd1);
        check("gap_sad",  32'(bif.best_sad),  32'd7);
        check("gap_addr", 32'(bif.best_addr), 32'hF7);
        step();

        // Restart mid-window; coincident sample is dropped.
        d0 = done_cnt;
        pulse_start();
        send(13'd30, 8'h40);
        send(13'd20, 8'h41);
        check("rs_cnt2", 32'(bif.cand_cnt), 32'd2);
        bif.start     = 1'b1;
        bif.res_valid = 1'b1;
        bif.res_in    = {13'd1, 8'h42};
        step();
        bif.start     = 1'b0;
        bif.res_valid = 1'b0;
        m_act  = 1'b1;
        m_sad  = 13'h1FFF;
        m_addr = 8'h00;
        m_cnt  = 0;
        check("rs_cnt0", 32'(bif.cand_cnt), 32'd0);
        check("rs_sad",  32'(bif.best_sad), 32'h1FFF);
        check("rs_busy", 32'(bif.busy),     32'd1);
        check("rs_nodn", 32'(done_cnt),     32'(d0));
        send(13'd9,  8'h50);
        send(13'd3,  8'h51);
        send(13'd3,  8'h52);
        send(13'd12, 8'h53);
        check("rs_done", 32'(bif.done),      32'd1);
        check("rs_bsad", 32'(bif.best_sad),  32'd3);
        check("rs_addr", 32'(bif.best_addr), 32'h51);
        check("rs_ndn",  32'(done_cnt),      32'(d0 + 1));
        step();

        // Asynchronous reset between edges aborts the window.
        d0 = done_cnt;
        pulse_start();
        send(13'd11, 8'h60);
        send(13'd12, 8'h61);
        #2;
        rst_n = 1'b0;
        m_act = 1'b0;
        #1;
        check("ar_busy", 32'(bif.busy),     32'd0);
        check("ar_sad",  32'(bif.best_sad), 32'h1FFF);
        check("ar_cnt",  32'(bif.cand_cnt), 32'd0);
        check("ar_done", 32'(bif.done),     32'd0);
        step();
        rst_n = 1'b1;
        idle(2);
        check("ar_nodn",  32'(done_cnt), 32'(d0));
        check("ar_busy2", 32'(bif.busy), 32'd0);

        // Early-exit stimulus, then restart while in DONE.
        pulse_start();
        send(13'd50, 8'h20);
        send(13'd20, 8'h21);
        send(13'd16, 8'h22);
`ifdef MAD_BEST_EARLY_EN
        check("ee_done", 32'(bif.done),      32'd1);
        check("ee_cnt",  32'(bif.cand_cnt),  32'd3);
        check("ee_sad",  32'(bif.best_sad),  32'd16);
        check("ee_addr", 32'(bif.best_addr), 32'h22);
`else
        check("ee_nodn", 32'(bif.done),     32'd0);
        check("ee_busy", 32'(bif.busy),     32'd1);
        check("ee_cnt",  32'(bif.cand_cnt), 32'd3);
        check("ee_sad",  32'(bif.best_sad), 32'd16);
        send(13'd99, 8'h23);
        check("ee_done", 32'(bif.done),      32'd1);
        check("ee_addr", 32'(bif.best_addr), 32'h22);
        check("ee_cnt4", 32'(bif.cand_cnt),  32'd4);
`endif
        d0 = done_cnt;
        pulse_start();
        check("dr_busy", 32'(bif.busy),     32'd1);
        check("dr_cnt",  32'(bif.cand_cnt), 32'd0);
        check("dr_sad",  32'(bif.best_sad), 32'h1FFF);
        send(13'd500, 8'h70);
        send(13'd300, 8'h71);
        send(13'd300, 8'h72);
        send(13'd400, 8'h73);
        check("dr_done", 32'(bif.done),      32'd1);
        check("dr_bsad", 32'(bif.best_sad),  32'd300);
        check("dr_addr", 32'(bif.best_addr), 32'h71);
        check("dr_ndn",  32'(done_cnt),      32'(d0 + 1));
        step();
        check("end_done",  32'(bif.done),  32'd0);
        check("sb_drain",  32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
